// File: rtl/rob_wb_arbiter_pkg.sv
// Shared ROB core constants: row width, tag layout {row, column} and the
// busy-clear port layout {EN, row, column}.
package rob_wb_arbiter_pkg;

  localparam int ROB_WIDTH_BANK = 3;
  localparam int ROB_WIDTH_TAG  = ROB_WIDTH_BANK + 2;
  localparam int ROB_WIDTH_BRST = 1 + ROB_WIDTH_TAG;
  localparam int NPORT          = 4;

  typedef struct packed {
    logic                      en;
    logic [ROB_WIDTH_BANK-1:0] row;
    logic [1:0]                col;
  } brst_t;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    popcnt8 = '0;
    for (int i = 0; i < 8; i++) begin
      popcnt8 = popcnt8 + {3'b000, v[i]};
    end
  endfunction

endpackage

// File: rtl/rob_wb_arbiter_if.sv
// Writeback bus between execution units and the ROB busy-clear ports.
interface rob_wb_arbiter_if
  import rob_wb_arbiter_pkg::*;
#(
  parameter int NREQ      = 6,
  parameter int WIDTH_TAG = ROB_WIDTH_TAG
);
  logic [NREQ-1:0]           i_req_valid;
  logic [NREQ*WIDTH_TAG-1:0] i_req_tag;
  logic [NREQ-1:0]           o_req_ready;
  logic                      i_flush;
  logic [WIDTH_TAG:0]        o_rst_busy0;
  logic [WIDTH_TAG:0]        o_rst_busy1;
  logic [WIDTH_TAG:0]        o_rst_busy2;
  logic [WIDTH_TAG:0]        o_rst_busy3;
  logic [3:0]                o_pending;

  modport master (
    output i_req_valid, i_req_tag, i_flush,
    input  o_req_ready, o_rst_busy0, o_rst_busy1, o_rst_busy2, o_rst_busy3, o_pending
  );

  modport slave (
    input  i_req_valid, i_req_tag, i_flush,
    output o_req_ready, o_rst_busy0, o_rst_busy1, o_rst_busy2, o_rst_busy3, o_pending
  );
endinterface

// File: rtl/rob_wb_arbiter_rr_pick4.sv
// Round-robin picker: up to four pending requesters from pointer rr, in scan
// order, as one-hot grants per port plus the advanced pointer.
module rr_pick4
  import rob_wb_arbiter_pkg::*;
#(
  parameter int NREQ     = 6,
  parameter int WIDTH_RR = 3
) (
  input  logic [NREQ-1:0]             pend_i,
  input  logic [WIDTH_RR-1:0]         rr_i,
  output logic [NPORT-1:0][NREQ-1:0]  grant_oh_o,
  output logic [NREQ-1:0]             grant_o,
  output logic [WIDTH_RR-1:0]         rr_o
);

  logic [WIDTH_RR:0]   sum;
  logic [WIDTH_RR-1:0] idx;
  logic [2:0]          cnt;

  always_comb begin
    grant_oh_o = '0;
    grant_o    = '0;
    rr_o       = rr_i;
    cnt        = '0;
    sum        = '0;
    idx        = '0;
    for (int off = 0; off < NREQ; off++) begin
      // wrap-around scan position without a modulo operator
      sum = {1'b0, rr_i} + (WIDTH_RR+1)'(off);
      if (sum >= (WIDTH_RR+1)'(NREQ)) begin
        sum = sum - (WIDTH_RR+1)'(NREQ);
      end
      idx = sum[WIDTH_RR-1:0];
      if (pend_i[idx] && (cnt < 3'd4)) begin
        grant_oh_o[cnt[1:0]][idx] = 1'b1;
        grant_o[idx]              = 1'b1;
        cnt                       = cnt + 3'd1;
        rr_o = (idx == WIDTH_RR'(NREQ-1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Writeback arbiter: one holding slot per execution unit, up to four
// completions per cycle forwarded to the ROB busy-clear ports.
module rob_wb_arbiter
  import rob_wb_arbiter_pkg::*;
#(
  parameter int WIDTH_BANK = ROB_WIDTH_BANK,
  parameter int NREQ       = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rob_wb_arbiter_if.slave bus
);

  localparam int WIDTH_TAG  = WIDTH_BANK + 2;
  localparam int WIDTH_BRST = 1 + WIDTH_TAG;
  localparam int WIDTH_RR   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]            pend_q, pend_d;
  logic [WIDTH_TAG-1:0]       tag_q [NREQ];
  logic [WIDTH_RR-1:0]        rr_q, rr_d, rr_pick;
  logic [WIDTH_BRST-1:0]      busy_q [NPORT];
  logic [WIDTH_BRST-1:0]      busy_d [NPORT];
  logic [3:0]                 pending_q, pending_d;
  logic [NPORT-1:0][NREQ-1:0] grant_oh;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            ready;
  logic [NREQ-1:0]            xfer;

  rr_pick4 #(
    .NREQ     (NREQ),
    .WIDTH_RR (WIDTH_RR)
  ) u_pick (
    .pend_i     (pend_q),
    .rr_i       (rr_q),
    .grant_oh_o (grant_oh),
    .grant_o    (grant),
    .rr_o       (rr_pick)
  );

  // a slot being drained this cycle can take the next completion back-to-back
  assign ready = (~pend_q | grant) & {NREQ{~bus.i_flush}};
  assign xfer  = bus.i_req_valid & ready;

  always_comb begin
    pend_d    = bus.i_flush ? '0 : ((pend_q & ~grant) | xfer);
    rr_d      = bus.i_flush ? rr_q : rr_pick;
    pending_d = popcnt8(8'(pend_d));
    for (int k = 0; k < NPORT; k++) begin
      busy_d[k] = '0;
      if (!bus.i_flush) begin
        for (int r = 0; r < NREQ; r++) begin
          if (grant_oh[k][r]) begin
            busy_d[k] = {1'b1, tag_q[r]};
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q    <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      for (int r = 0; r < NREQ; r++) begin
        tag_q[r] <= '0;
      end
      for (int k = 0; k < NPORT; k++) begin
        busy_q[k] <= '0;
      end
    end else begin
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      for (int r = 0; r < NREQ; r++) begin
        if (xfer[r]) begin
          tag_q[r] <= bus.i_req_tag[r*WIDTH_TAG +: WIDTH_TAG];
        end
      end
      for (int k = 0; k < NPORT; k++) begin
        busy_q[k] <= busy_d[k];
      end
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_rst_busy0 = busy_q[0];
  assign bus.o_rst_busy1 = busy_q[1];
  assign bus.o_rst_busy2 = busy_q[2];
  assign bus.o_rst_busy3 = busy_q[3];
  assign bus.o_pending   = pending_q;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Randomised scoreboard bench for rob_wb_arbiter against a queue-based model.
module tb_rob_wb_arbiter;

  localparam int N  = 6;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rob_wb_arbiter_if #(.NREQ(N), .WIDTH_TAG(TW)) bus ();

  rob_wb_arbiter #(.WIDTH_BANK(3), .NREQ(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  tag;
    int          req;
  } exp_t;

  exp_t       expq [4][$];
  logic [5:0] m_pend = '0;
  logic [4:0] m_tag [N];
  int         m_rr = 0;
  int         m_acc [N];
  int         obs_cnt [N];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_tag[i]   = '0;
      m_acc[i]   = 0;
      obs_cnt[i] = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // requesters pending, visited from pointer r with wrap, first four win
  function automatic int pick(input logic [5:0] p, input int r, output int g [4]);
    int n = 0;
    for (int j = 0; j < 4; j++) g[j] = 0;
    for (int o = 0; o < N; o++) begin
      int i = (r + o) % N;
      if (p[i] && n < 4) begin
        g[n] = i;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] ones(input logic [5:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return 4'(c);
  endfunction

  function automatic logic [5:0] model_ready();
    int g [4];
    int n;
    logic [5:0] r;
    n = pick(m_pend, m_rr, g);
    r = ~m_pend;
    for (int j = 0; j < n; j++) r[g[j]] = 1'b1;
    if (bus.i_flush) r = '0;
    return r;
  endfunction

  // reference model, advanced on every active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0;
      m_rr   = 0;
      for (int k = 0; k < 4; k++) expq[k].delete();
    end else begin
      int g [4];
      int n;
      logic [5:0] rdy;
      cyc++;
      rdy = model_ready();
      n   = pick(m_pend, m_rr, g);
      if (bus.i_flush) begin
        m_pend = '0;
      end else begin
        for (int j = 0; j < n; j++) begin
          expq[j].push_back('{cyc, m_tag[g[j]], g[j]});
          m_pend[g[j]] = 1'b0;
        end
        if (n > 0) m_rr = (g[n-1] + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (bus.i_req_valid[i] && rdy[i]) begin
            m_pend[i] = 1'b1;
            m_tag[i]  = bus.i_req_tag[i*TW +: TW];
            m_acc[i]++;
          end
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever a port presents a completion
  always @(negedge clk) begin
    if (rst_n) begin
      logic [5:0] pv [4];
      exp_t e;
      pv[0] = bus.o_rst_busy0;
      pv[1] = bus.o_rst_busy1;
      pv[2] = bus.o_rst_busy2;
      pv[3] = bus.o_rst_busy3;
      chk("ready", 32'(bus.o_req_ready), 32'(model_ready()));
      chk("pending", 32'(bus.o_pending), 32'(ones(m_pend)));
      for (int k = 0; k < 4; k++) begin
        if (pv[k][5]) begin
          obs_cnt[pv[k][4:2] % N]++;
          if (expq[k].size() == 0) begin
            chk($sformatf("port%0d_unexpected", k), 32'(pv[k]), 32'd0);
          end else begin
            e = expq[k].pop_front();
            chk($sformatf("port%0d_cycle", k), 32'(cyc), 32'(e.cyc));
            chk($sformatf("port%0d_tag_req%0d", k, e.req), 32'(pv[k][4:0]), 32'(e.tag));
          end
        end else begin
          chk($sformatf("port%0d_idle", k), 32'(pv[k]), 32'd0);
          if (expq[k].size() > 0 && expq[k][0].cyc <= cyc) begin
            e = expq[k].pop_front();
            chk($sformatf("port%0d_missing_req%0d", k, e.req), 32'(pv[k]), 32'({1'b1, e.tag}));
          end
        end
      end
    end
  end

  task automatic idle();
    bus.i_req_valid = '0;
    bus.i_req_tag   = '0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_in(input logic [5:0] v, input logic [29:0] t, input logic f);
    bus.i_req_valid = v;
    bus.i_req_tag   = t;
    bus.i_flush     = f;
    sync();
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] t;
    int s_obs [N];
    int s_acc [N];
    int mx, mn, d;

    idle();
    reset_dut();

    // idle after reset
    @(negedge clk);
    chk("rst_busy0", 32'(bus.o_rst_busy0), 32'd0);
    chk("rst_busy3", 32'(bus.o_rst_busy3), 32'd0);
    chk("rst_ready", 32'(bus.o_req_ready), 32'h3f);
    chk("rst_pending", 32'(bus.o_pending), 32'd0);
    sync();

    // four completions in one cycle, row 0 columns 0..3
    cycle_in(6'b001111, {5'd0, 5'd0, 5'd3, 5'd2, 5'd1, 5'd0}, 1'b0);
    idle();
    @(negedge clk);
    chk("quad_pending", 32'(bus.o_pending), 32'd4);
    @(posedge clk);
    @(negedge clk);
    chk("quad_p0", 32'(bus.o_rst_busy0), 32'b100000);
    chk("quad_p1", 32'(bus.o_rst_busy1), 32'b100001);
    chk("quad_p2", 32'(bus.o_rst_busy2), 32'b100010);
    chk("quad_p3", 32'(bus.o_rst_busy3), 32'b100011);
    @(negedge clk);
    chk("quad_done", 32'({bus.o_rst_busy0[5], bus.o_rst_busy1[5], bus.o_rst_busy2[5], bus.o_rst_busy3[5]}), 32'd0);
    sync();

    // all six once from pointer 0: two grant cycles
    reset_dut();
    sync();
    cycle_in(6'h3f, 30'($urandom), 1'b0);
    idle();
    repeat (4) sync();

    // saturation: all six every cycle, requester index in tag row
    for (int i = 0; i < N; i++) begin
      s_obs[i] = obs_cnt[i];
      s_acc[i] = m_acc[i];
    end
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) t[i*TW +: TW] = {3'(i), 2'($urandom_range(3))};
      cycle_in(6'h3f, t, 1'b0);
    end
    idle();
    repeat (6) sync();
    mx = 0;
    mn = 1000;
    for (int i = 0; i < N; i++) begin
      d = obs_cnt[i] - s_obs[i];
      chk($sformatf("sat_count_req%0d", i), 32'(d), 32'(m_acc[i] - s_acc[i]));
      if (d > mx) mx = d;
      if (d < mn) mn = d;
    end
    chk("sat_fair_spread_le1", 32'(mx - mn <= 1), 32'd1);

    // flush while requesters 1,2 pending; flush-cycle requests refused
    cycle_in(6'b000110, 30'($urandom), 1'b0);
    cycle_in(6'h3f, 30'($urandom), 1'b1);
    idle();
    @(negedge clk);
    chk("flush_en", 32'({bus.o_rst_busy0[5], bus.o_rst_busy1[5], bus.o_rst_busy2[5], bus.o_rst_busy3[5]}), 32'd0);
    chk("flush_pending", 32'(bus.o_pending), 32'd0);
    sync();
    repeat (2) sync();

    // random traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      cycle_in(6'($urandom), 30'($urandom), ($urandom_range(15) == 0));
    end
    idle();
    repeat (4) sync();

    // asynchronous reset with five pending
    cycle_in(6'b011111, 30'($urandom), 1'b0);
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'({bus.o_rst_busy0, bus.o_rst_busy1, bus.o_rst_busy2, bus.o_rst_busy3}), 32'd0);
    chk("arst_pending", 32'(bus.o_pending), 32'd0);
    chk("arst_ready", 32'(bus.o_req_ready), 32'h3f);
    #2 rst_n = 1'b1;
    repeat (5) sync();

    chk("drain_empty", 32'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
